// File: rtl/coherent_tone_gen.sv
// Impulse / coherent sine-burst stimulus source feeding a filter input.
// Define COHERENT_TONE_GEN_CLIP_COUNT_EN to add the clip_cnt saturation counter output.
`timescale 1ns/1ps
module coherent_tone_gen #(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic signed [DW-1:0] amp,
    input  logic signed [17:0]   coef,
    input  logic signed [DW-1:0] seed,
    input  logic [7:0]           period,
    input  logic [15:0]          count,
    input  logic [7:0]           delay,
    output logic signed [DW-1:0] out,
    output logic                 oe,
    output logic                 busy,
    output logic                 done
`ifdef COHERENT_TONE_GEN_CLIP_COUNT_EN
    ,
    output logic [7:0]           clip_cnt
`endif
);

    localparam int PW = 18 + DW;
    localparam logic signed [PW-1:0] RND  = PW'(32768);
    localparam logic signed [PW-1:0] SMAX = PW'((1 << (DW-1)) - 1);
    localparam logic signed [PW-1:0] SMIN = -SMAX;
    localparam logic signed [DW-1:0] OMAX = DW'((1 << (DW-1)) - 1);
    localparam logic signed [DW-1:0] OMIN = -OMAX;

    typedef enum logic [1:0] {IDLE, DELAY, RUN, FIN} state_t;

    state_t                r_state, w_state;
    logic                  r_mode;
    logic signed [DW-1:0]  r_amp;
    logic signed [17:0]    r_coef;
    logic signed [DW-1:0]  r_seed;
    logic [7:0]            r_period;
    logic [15:0]           r_count;
    logic [7:0]            r_dcnt, w_dcnt;
    logic [15:0]           r_scnt, w_scnt;
    logic [7:0]            r_phase, w_phase;
    logic signed [DW-1:0]  r_out, w_out;
    logic signed [DW-1:0]  r_y2, w_y2;
    logic                  r_oe, w_oe;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;

    logic                  w_accept;
    logic                  w_activate;
    logic                  w_selMode;
    logic signed [DW-1:0]  w_selAmp;
    logic [15:0]           w_selCount;
    logic [7:0]            w_phNext;
    logic signed [PW-1:0]  w_prod, w_round, w_shifted, w_y2ext, w_diff;
    logic signed [DW-1:0]  w_sat;

    assign w_accept   = (r_state == IDLE) && start;
    // On the acceptance cycle the live inputs are used, afterwards only the captured copies.
    assign w_selMode  = (r_state == IDLE) ? mode  : r_mode;
    assign w_selAmp   = (r_state == IDLE) ? amp   : r_amp;
    assign w_selCount = (r_state == IDLE) ? count : r_count;
    assign w_phNext   = (r_phase == r_period - 8'd1) ? 8'd0 : r_phase + 8'd1;

    // Resonator step: y = sat(round(coef*y1 / 2^16) - y2), y1 being the sample currently on out.
    assign w_prod    = {{DW{r_coef[17]}}, r_coef} * {{18{r_out[DW-1]}}, r_out};
    assign w_round   = w_prod + RND;
    assign w_shifted = w_round >>> 16;
    assign w_y2ext   = {{18{r_y2[DW-1]}}, r_y2};
    assign w_diff    = w_shifted - w_y2ext;

    always_comb begin
        if (w_diff > SMAX)
            w_sat = OMAX;
        else if (w_diff < SMIN)
            w_sat = OMIN;
        else
            w_sat = w_diff[DW-1:0];
    end

    always_comb begin
        w_state    = r_state;
        w_dcnt     = r_dcnt;
        w_scnt     = r_scnt;
        w_phase    = r_phase;
        w_out      = '0;
        w_y2       = r_y2;
        w_oe       = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_activate = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (delay != 8'd0) begin
                        w_state = DELAY;
                        w_dcnt  = delay - 8'd1;
                        w_oe    = 1'b1;
                        w_busy  = 1'b1;
                    end else begin
                        w_activate = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (r_dcnt != 8'd0) begin
                    w_dcnt = r_dcnt - 8'd1;
                    w_oe   = 1'b1;
                    w_busy = 1'b1;
                end else begin
                    w_activate = 1'b1;
                end
            end
            RUN: begin
                if (!r_mode || (r_scnt == r_count)) begin
                    w_state = FIN;
                    w_done  = 1'b1;
                end else begin
                    w_phase = w_phNext;
                    w_scnt  = r_scnt + 16'd1;
                    w_y2    = r_out;
                    w_oe    = 1'b1;
                    w_busy  = 1'b1;
                    if (w_phNext == 8'd0)
                        w_out = '0;
                    else if (w_phNext == 8'd1)
                        w_out = r_seed;
                    else
                        w_out = w_sat;
                end
            end
            FIN: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
        // Emission of the first active sample, shared by the IDLE and DELAY exits.
        if (w_activate) begin
            if (!w_selMode) begin
                w_state = RUN;
                w_out   = w_selAmp;
                w_oe    = 1'b1;
                w_busy  = 1'b1;
            end else if (w_selCount == 16'd0) begin
                w_state = FIN;
                w_done  = 1'b1;
            end else begin
                w_state = RUN;
                w_phase = 8'd0;
                w_scnt  = 16'd1;
                w_y2    = '0;
                w_oe    = 1'b1;
                w_busy  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mode   <= 1'b0;
            r_amp    <= '0;
            r_coef   <= '0;
            r_seed   <= '0;
            r_period <= '0;
            r_count  <= '0;
            r_dcnt   <= '0;
            r_scnt   <= '0;
            r_phase  <= '0;
            r_out    <= '0;
            r_y2     <= '0;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_dcnt  <= w_dcnt;
            r_scnt  <= w_scnt;
            r_phase <= w_phase;
            r_out   <= w_out;
            r_y2    <= w_y2;
            r_oe    <= w_oe;
            r_busy  <= w_busy;
            r_done  <= w_done;
            if (w_accept) begin
                r_mode   <= mode;
                r_amp    <= amp;
                r_coef   <= coef;
                r_seed   <= seed;
                r_period <= period;
                r_count  <= count;
            end
        end
    end

    assign out  = r_out;
    assign oe   = r_oe;
    assign busy = r_busy;
    assign done = r_done;

`ifdef COHERENT_TONE_GEN_CLIP_COUNT_EN
    logic       w_clipEv;
    logic [7:0] r_clipCnt;

    assign w_clipEv = (r_state == RUN) && r_mode && (r_scnt != r_count) &&
                      (w_phNext >= 8'd2) && ((w_diff > SMAX) || (w_diff < SMIN));

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_clipCnt <= '0;
        else if (w_accept)
            r_clipCnt <= '0;
        else if (w_clipEv && (r_clipCnt != 8'd255))
            r_clipCnt <= r_clipCnt + 8'd1;
    end

    assign clip_cnt = r_clipCnt;
`endif

endmodule

// File: tb/tb_coherent_tone_gen.sv
// Scoreboard bench for coherent_tone_gen: expected samples are queued at start and popped each cycle.
`timescale 1ns/1ps
module tb_coherent_tone_gen;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               mode;
    logic signed [15:0] amp;
    logic signed [17:0] coef;
    logic signed [15:0] seed;
    logic [7:0]         period;
    logic [15:0]        count;
    logic [7:0]         delay;
    logic signed [15:0] out;
    logic               oe;
    logic               busy;
    logic               done;
`ifdef COHERENT_TONE_GEN_CLIP_COUNT_EN
    logic [7:0]         clip_cnt;
`endif

    typedef struct {
        logic signed [15:0] out;
        logic               oe;
        logic               busy;
        logic               done;
    } exp_t;

    exp_t  sbQ[$];
    int    checks = 0;
    int    errors = 0;
    int    busyCnt = 0;
    int    sampleIdx = 0;
    int    modelClips = 0;
    string tag = "init";

    always #5 clk = ~clk;

    coherent_tone_gen #(.DW(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .amp    (amp),
        .coef   (coef),
        .seed   (seed),
        .period (period),
        .count  (count),
        .delay  (delay),
        .out    (out),
        .oe     (oe),
        .busy   (busy),
        .done   (done)
`ifdef COHERENT_TONE_GEN_CLIP_COUNT_EN
        ,
        .clip_cnt (clip_cnt)
`endif
    );

    // Reference resonator step with symmetric clipping.
    function automatic longint modelSample(input longint cf, input longint y1, input longint y2,
                                           output bit clipped);
        longint r;
        r = ((cf * y1 + 64'sd32768) >>> 16) - y2;
        clipped = 1'b0;
        if (r > 32767) begin
            r = 32767;
            clipped = 1'b1;
        end else if (r < -32767) begin
            r = -32767;
            clipped = 1'b1;
        end
        return r;
    endfunction

    task automatic pushExp(input logic signed [15:0] o, input logic e, input logic b, input logic d);
        exp_t x;
        x.out = o;
        x.oe = e;
        x.busy = b;
        x.done = d;
        sbQ.push_back(x);
    endtask

    task automatic applyStimulus(input string t, input logic m, input int a, input int c, input int s,
                                 input int per, input int cnt, input int dly);
        longint y1, y2, sv;
        bit     clp;
        tag = t;
        sampleIdx = 0;
        modelClips = 0;
        mode = m;
        amp = 16'(a);
        coef = 18'(c);
        seed = 16'(s);
        period = 8'(per);
        count = 16'(cnt);
        delay = 8'(dly);
        start = 1'b1;
        for (int i = 0; i < dly; i++)
            pushExp(16'sd0, 1'b1, 1'b1, 1'b0);
        if (!m) begin
            pushExp(16'(a), 1'b1, 1'b1, 1'b0);
        end else begin
            y1 = 0;
            y2 = 0;
            for (int i = 0; i < cnt; i++) begin
                if ((i % per) == 0) begin
                    sv = 0;
                end else if ((i % per) == 1) begin
                    sv = s;
                end else begin
                    sv = modelSample(c, y1, y2, clp);
                    if (clp) modelClips++;
                end
                pushExp(16'(sv), 1'b1, 1'b1, 1'b0);
                y2 = y1;
                y1 = sv;
            end
        end
        pushExp(16'sd0, 1'b0, 1'b0, 1'b1);
        pushExp(16'sd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput();
        exp_t e;
        e = sbQ.pop_front();
        checks++;
        assert (out === e.out) else begin
            errors++;
            $error("[TB] FAIL %s[%0d] out got %0d want %0d", tag, sampleIdx, out, e.out);
        end
        checks++;
        assert (oe === e.oe) else begin
            errors++;
            $error("[TB] FAIL %s[%0d] oe got %b want %b", tag, sampleIdx, oe, e.oe);
        end
        checks++;
        assert (busy === e.busy) else begin
            errors++;
            $error("[TB] FAIL %s[%0d] busy got %b want %b", tag, sampleIdx, busy, e.busy);
        end
        checks++;
        assert (done === e.done) else begin
            errors++;
            $error("[TB] FAIL %s[%0d] done got %b want %b", tag, sampleIdx, done, e.done);
        end
        if (busy === 1'b1) busyCnt++;
        sampleIdx++;
    endtask

    // One check per cycle until the queue drains; pokeAt raises start after that check, scramble churns inputs.
    task automatic runUntilEmpty(input int budget, input int pokeAt, input bit scramble);
        int i;
        i = 0;
        while ((sbQ.size() > 0) && (i < budget)) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (scramble) begin
                mode   = 1'($urandom);
                amp    = 16'($urandom);
                coef   = 18'($urandom);
                seed   = 16'($urandom);
                period = 8'($urandom_range(2, 255));
                count  = 16'($urandom);
                delay  = 8'($urandom);
            end
            checkOutput();
            if (i == pokeAt) start = 1'b1;
            i++;
        end
        start = 1'b0;
        checks++;
        assert (sbQ.size() == 0) else begin
            errors++;
            $error("[TB] FAIL %s budget got %0d pending entries want 0", tag, sbQ.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode = 1'b0;
        amp = '0;
        coef = '0;
        seed = '0;
        period = 8'd2;
        count = '0;
        delay = '0;
        tag = "reset";
        sampleIdx = 0;
        repeat (3) pushExp(16'sd0, 1'b0, 1'b0, 1'b0);
        runUntilEmpty(10, -1, 1'b0);
        rst_n = 1'b1;

        // Impulse after ten zero samples; start raised during FIN must not retrigger.
        applyStimulus("impulse", 1'b0, 30000, 0, 0, 2, 0, 10);
        runUntilEmpty(40, 11, 1'b0);

        // Coherent burst with inputs churning after acceptance and a start pulse mid-run.
        busyCnt = 0;
        applyStimulus("burst7", 1'b1, 0, 81722, 2736, 7, 100, 0);
        runUntilEmpty(200, 20, 1'b1);
        checks++;
        assert (busyCnt == 100) else begin
            errors++;
            $error("[TB] FAIL burst7 busy cycles got %0d want 100", busyCnt);
        end

        applyStimulus("saturate", 1'b1, 0, 131071, 30000, 200, 3, 0);
        runUntilEmpty(20, -1, 1'b0);
`ifdef COHERENT_TONE_GEN_CLIP_COUNT_EN
        checks++;
        assert (clip_cnt === 8'(modelClips)) else begin
            errors++;
            $error("[TB] FAIL saturate clip_cnt got %0d want %0d", clip_cnt, modelClips);
        end
`endif

        applyStimulus("count0", 1'b1, 0, 81722, 2736, 7, 0, 3);
        runUntilEmpty(20, 3, 1'b0);

        applyStimulus("burst5", 1'b1, 0, 40503, 9511, 5, 12, 2);
        runUntilEmpty(40, -1, 1'b0);

        applyStimulus("impneg", 1'b0, -1234, 0, 0, 2, 500, 0);
        runUntilEmpty(10, -1, 1'b0);

        // Reset while the burst is running: outputs drop next cycle and no done follows.
        applyStimulus("rstmid", 1'b1, 0, 81722, 2736, 7, 100, 0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            checkOutput();
        end
        rst_n = 1'b0;
        sbQ.delete();
        tag = "rstmid-after";
        sampleIdx = 0;
        repeat (4) pushExp(16'sd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput();
        runUntilEmpty(10, -1, 1'b0);

        applyStimulus("recover", 1'b0, 777, 0, 0, 2, 0, 1);
        runUntilEmpty(10, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
